bit_index_serializer: RTL and testbench

Expands an accepted WIDTH-bit word into a stream of the indices of its set bits, one index per output beat, in ascending order, lowest index first. It is the inverse of the population counter. The counter compresses a word to a ones-count; this block emits one beat per set bit, and the last beat carries an ordinal equal to that count. It sits downstream of word producers and feeds index-consuming logic over ready/valid handshakes.

---
 rtl/bit_index_serializer_if.sv | 42 ++++
 rtl/bit_index_serializer.sv | 138 +++++++++++++
 tb/tb_bit_index_serializer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_index_serializer_if.sv
// Handshake bundle for the bit-index serializer: word input side and
// index output side. The slave modport is the serializer itself; the
// master modport is whatever produces words and consumes indices.
interface bit_index_serializer_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] data_i;
    logic             data_val_i;
    logic             data_rdy_o;
    logic [IW-1:0]    index_o;
    logic             index_val_o;
    logic             index_rdy_i;
    logic             index_last_o;
    logic             zero_o;
    logic [IW:0]      seq_o;

    modport master (
        output data_i,
        output data_val_i,
        output index_rdy_i,
        input  data_rdy_o,
        input  index_o,
        input  index_val_o,
        input  index_last_o,
        input  zero_o,
        input  seq_o
    );

    modport slave (
        input  data_i,
        input  data_val_i,
        input  index_rdy_i,
        output data_rdy_o,
        output index_o,
        output index_val_o,
        output index_last_o,
        output zero_o,
        output seq_o
    );
endinterface

// File: rtl/bit_index_serializer.sv
// Bit-index serializer: accepts one WIDTH-bit word and emits the positions
// of its set bits, lowest first, one beat per set bit. An all-zero word
// still produces a single beat flagged with zero_o so the consumer always
// sees a terminating last beat for every accepted word.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a word; data_rdy_o high once out of reset
// EMIT  | presenting index beats; remainder holds bits not yet sent
module bit_index_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst_n_i,
    bit_index_serializer_if.slave bus
);

    localparam int IW = $clog2(WIDTH);
    localparam int SW = IW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] remainder;
    logic [IW-1:0]    index_q;
    logic [SW-1:0]    seq_q;
    logic             val_q;
    logic             rdy_q;
    logic             last_q;
    logic             zero_q;

    logic [IW-1:0]    in_lsb;
    logic [WIDTH-1:0] in_rest;
    logic [IW-1:0]    rem_lsb;
    logic [WIDTH-1:0] rem_rest;

    // Position of the lowest set bit; scanning downward lets the lowest
    // hit overwrite any higher one. Returns 0 for an all-zero word.
    function automatic logic [IW-1:0] lowest_set(input logic [WIDTH-1:0] w);
        logic [IW-1:0] pos;
        pos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w[i]) begin
                pos = IW'(i);
            end
        end
        return pos;
    endfunction

    // Lowest-bit lookup and clear for both the incoming word and the
    // remainder; w & (w-1) drops exactly the lowest set bit.
    always_comb begin
        in_lsb   = lowest_set(bus.data_i);
        in_rest  = bus.data_i & (bus.data_i - WIDTH'(1));
        rem_lsb  = lowest_set(remainder);
        rem_rest = remainder & (remainder - WIDTH'(1));
    end

    // Sequencing FSM with all outputs registered. data_rdy_o is held low
    // through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state     <= IDLE;
            remainder <= '0;
            index_q   <= '0;
            seq_q     <= '0;
            val_q     <= 1'b0;
            rdy_q     <= 1'b0;
            last_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    val_q <= 1'b0;
                    if (rdy_q && bus.data_val_i) begin
                        state <= EMIT;
                        rdy_q <= 1'b0;
                        val_q <= 1'b1;
                        if (bus.data_i == '0) begin
                            index_q   <= '0;
                            remainder <= '0;
                            seq_q     <= '0;
                            last_q    <= 1'b1;
                            zero_q    <= 1'b1;
                        end else begin
                            index_q   <= in_lsb;
                            remainder <= in_rest;
                            seq_q     <= SW'(1);
                            last_q    <= (in_rest == '0);
                            zero_q    <= 1'b0;
                        end
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end

                EMIT: begin
                    // val_q is always high here, so index_rdy_i alone
                    // completes the beat; otherwise everything holds.
                    if (bus.index_rdy_i) begin
                        if (last_q) begin
                            state     <= IDLE;
                            val_q     <= 1'b0;
                            rdy_q     <= 1'b1;
                            index_q   <= '0;
                            seq_q     <= '0;
                            last_q    <= 1'b0;
                            zero_q    <= 1'b0;
                            remainder <= '0;
                        end else begin
                            index_q   <= rem_lsb;
                            remainder <= rem_rest;
                            seq_q     <= seq_q + SW'(1);
                            last_q    <= (rem_rest == '0);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    val_q <= 1'b0;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_rdy_o   = rdy_q;
    assign bus.index_val_o  = val_q;
    assign bus.index_o      = index_q;
    assign bus.index_last_o = last_q;
    assign bus.zero_o       = zero_q;
    assign bus.seq_o        = seq_q;

endmodule

// File: tb/tb_bit_index_serializer.sv
// Bench for the bit-index serializer: a queue-based model of the beats each
// accepted word must produce, checked against the DUT every cycle, plus
// directed words with literal beat lists and a randomized regression.
module tb_bit_index_serializer;

    localparam int WIDTH = 8;

    typedef struct {
        int idx;
        int seq;
        bit last;
        bit zero;
    } beat_t;

    logic clk;
    logic arst_n_i;

    bit_index_serializer_if #(.WIDTH(WIDTH)) bus ();

    bit_index_serializer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .arst_n_i (arst_n_i),
        .bus      (bus.slave)
    );

    int    checks = 0;
    int    errors = 0;
    bit    armed  = 0;
    int    words_done = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat list of a word, straight from the definition: one beat
    // per set bit in ascending order, ordinals counting from 1, a single
    // flagged beat for zero.
    function automatic void model_push(input logic [WIDTH-1:0] w);
        int total;
        int cnt;
        beat_t b;
        total = $countones(w);
        cnt = 0;
        if (total == 0) begin
            b.idx = 0; b.seq = 0; b.last = 1'b1; b.zero = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w[i]) begin
                    cnt++;
                    b.idx = i; b.seq = cnt; b.last = (cnt == total); b.zero = 1'b0;
                    exp_q.push_back(b);
                end
            end
        end
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (armed && arst_n_i) begin
            beat_t o;
            chk("data_rdy", bus.data_rdy_o, exp_q.size() == 0);
            chk("index_val", bus.index_val_o, exp_q.size() != 0);
            if (bus.index_val_o && exp_q.size() != 0) begin
                chk("index", bus.index_o, exp_q[0].idx);
                chk("seq", bus.seq_o, exp_q[0].seq);
                chk("last", bus.index_last_o, exp_q[0].last);
                chk("zero", bus.zero_o, exp_q[0].zero);
                if (bus.index_rdy_i) begin
                    o.idx  = int'(bus.index_o);
                    o.seq  = int'(bus.seq_o);
                    o.last = bus.index_last_o;
                    o.zero = bus.zero_o;
                    obs_q.push_back(o);
                    if (exp_q[0].last) words_done++;
                    void'(exp_q.pop_front());
                end
            end
            if (bus.data_rdy_o && bus.data_val_i) model_push(bus.data_i);
        end
    end

    task automatic do_reset();
        arst_n_i = 1'b0;
        bus.data_val_i = 1'b0;
        #1;
        chk("rst_index_val", bus.index_val_o, 0);
        chk("rst_index", bus.index_o, 0);
        chk("rst_last", bus.index_last_o, 0);
        chk("rst_zero", bus.zero_o, 0);
        chk("rst_seq", bus.seq_o, 0);
        chk("rst_data_rdy", bus.data_rdy_o, 0);
        armed = 0;
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 arst_n_i = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_data_rdy", bus.data_rdy_o, 1);
        chk("post_rst_index_val", bus.index_val_o, 0);
        armed = 1;
    endtask

    // Present w until accepted; mode 0 keeps index_rdy_i high, mode 1
    // randomizes it. Junk on data_i/data_val_i while busy must be ignored.
    task automatic send_word(input logic [WIDTH-1:0] w, input int mode, input bit junk);
        int target;
        int t;
        target = words_done + 1;
        @(posedge clk);
        #1;
        bus.data_i = w;
        bus.data_val_i = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.data_rdy_o) break;
            t++;
            if (t > 50) begin
                chk("accept_timeout", 1, 0);
                bus.data_val_i = 1'b0;
                return;
            end
        end
        t = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.index_rdy_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.data_val_i  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.data_i      = WIDTH'($urandom);
            @(negedge clk);
            #1;
            if (words_done >= target) break;
            t++;
            if (t > 200) begin
                chk("word_timeout", 1, 0);
                break;
            end
        end
        bus.data_val_i = 1'b0;
    endtask

    task automatic chk_beat(input string name, input int k, input int idx,
                            input int seq, input bit last, input bit zero);
        if (obs_q.size() <= k) begin
            chk({name, "_missing"}, obs_q.size(), k + 1);
        end else begin
            chk({name, "_idx"}, obs_q[k].idx, idx);
            chk({name, "_seq"}, obs_q[k].seq, seq);
            chk({name, "_last"}, obs_q[k].last, last);
            chk({name, "_zero"}, obs_q[k].zero, zero);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] rebuilt;
        int t;
        bit mono;

        arst_n_i = 1'b1;
        bus.data_i = '0;
        bus.data_val_i = 1'b0;
        bus.index_rdy_i = 1'b1;
        #3;
        do_reset();

        // 8'b1010_0110 -> (1,1,0) (2,2,0) (5,3,0) (7,4,1)
        obs_q.delete();
        send_word(8'hA6, 0, 0);
        chk("a6_beats", obs_q.size(), 4);
        chk_beat("a6_b0", 0, 1, 1, 0, 0);
        chk_beat("a6_b1", 1, 2, 2, 0, 0);
        chk_beat("a6_b2", 2, 5, 3, 0, 0);
        chk_beat("a6_b3", 3, 7, 4, 1, 0);
        @(posedge clk);
        #1 chk("a6_rdy_after", bus.data_rdy_o, 1);

        obs_q.delete();
        send_word(8'h00, 0, 0);
        chk("zero_beats", obs_q.size(), 1);
        chk_beat("zero_b0", 0, 0, 0, 1, 1);

        obs_q.delete();
        send_word(8'hFF, 0, 0);
        chk("ff_beats", obs_q.size(), 8);
        for (int i = 0; i < 8; i++) chk_beat("ff", i, i, i + 1, i == 7, 0);

        obs_q.delete();
        send_word(8'h80, 0, 0);
        chk("msb_beats", obs_q.size(), 1);
        chk_beat("msb_b0", 0, 7, 1, 1, 0);

        obs_q.delete();
        send_word(8'h11, 1, 1);
        chk("bp_beats", obs_q.size(), 2);
        chk_beat("bp_b0", 0, 0, 1, 0, 0);
        chk_beat("bp_b1", 1, 4, 2, 1, 0);

        // Reset after the first beat of 8'hF0, then a fresh word.
        obs_q.delete();
        @(posedge clk);
        #1;
        bus.data_i = 8'hF0;
        bus.data_val_i = 1'b1;
        bus.index_rdy_i = 1'b1;
        t = 0;
        while (obs_q.size() < 1 && t < 50) begin
            @(negedge clk);
            #1;
            if (!bus.data_rdy_o) bus.data_val_i = 1'b0;
            t++;
        end
        chk("f0_first_beat_seen", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("f0_first_idx", obs_q[0].idx, 4);
        #1;
        do_reset();
        send_word(8'h02, 0, 0);
        chk("after_rst_beats", obs_q.size(), 1);
        chk_beat("after_rst_b0", 0, 1, 1, 1, 0);

        // Randomized regression.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0:       w = '0;
                1:       w = '1;
                2:       w = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                default: w = WIDTH'($urandom);
            endcase
            obs_q.delete();
            send_word(w, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
            rebuilt = '0;
            mono = 1'b1;
            for (int k = 0; k < obs_q.size(); k++) begin
                if (!obs_q[k].zero) rebuilt[obs_q[k].idx] = 1'b1;
                if (k > 0 && obs_q[k].idx <= obs_q[k-1].idx) mono = 1'b0;
            end
            chk("rnd_rebuild", rebuilt, w);
            chk("rnd_increasing", mono, 1);
            if (obs_q.size() > 0) begin
                chk("rnd_last_seq", obs_q[obs_q.size()-1].seq, $countones(w));
            end else begin
                chk("rnd_no_beats", 0, 1);
            end
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
